lcd_bus_arbiter: RTL and testbench

- Owns the 4-bit HD44780-style LCD write port and shares it between two byte-level requesters, e.g. a text writer and a command/cursor client.
- After reset, sends the fixed 4-bit init sequence, then grants the bus round-robin.
- Splits each granted byte into high and low nibbles with tick-paced enable pulses.
- Inserts extra settle time after clear/home commands.

---
 rtl/lcd_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a 4-bit HD44780-style LCD write port: power-up wait, init sequence,
// round-robin byte grants and tick-paced nibble strobes. Define LCD_LOCK_EN to add owner lock inputs.
module lcd_bus_arbiter #(
  parameter int DIV       = 25000,
  parameter int CLR_TICKS = 16,
  parameter int PWR_TICKS = 40
) (
  input  logic       clk,
  input  logic       sw_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] dat0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] dat1,
  output logic       ack1,
`ifdef LCD_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [3:0] lcd_db,
  output logic       busy,
  output logic       init_done,
  output logic       owner
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {PWR, INIT, IDLE, H_EN, H_LO, L_EN, L_LO, GAP} state_t;

  state_t          state, state_n, post;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [15:0]     wcnt, wcnt_n;
  logic [1:0]      init_idx;
  logic [7:0]      byte_q, nxt_byte;
  logic            rs_q, nxt_rs;
  logic            gnt0, gnt1, pick0, pick1, own_lock;
  logic            take_post, set_done, idx_inc, clr_cmd;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign tick    = (tick_cnt == TW'(DIV - 1));
  assign clr_cmd = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
  assign busy    = (state != IDLE);
  assign lcd_rw  = 1'b0;
  assign ack0    = gnt0;
  assign ack1    = gnt1;

`ifdef LCD_LOCK_EN
  assign own_lock = owner ? lock1 : lock0;
`else
  assign own_lock = 1'b0;
`endif

  // A held lock pins the grant to the current owner; otherwise ties go opposite to owner.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (own_lock) begin
      pick0 = !owner && req0;
      pick1 = owner && req1;
    end else begin
      pick0 = req0 && (!req1 || owner);
      pick1 = req1 && (!req0 || !owner);
    end
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = '0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    nxt_rs    = rs_q;
    nxt_byte  = byte_q;
    take_post = 1'b0;
    post      = (init_done || init_idx == 2'd3) ? IDLE : INIT;
    case (state)
      PWR:  if (int'(wcnt) + 1 >= PWR_TICKS) state_n = INIT;
            else wcnt_n = wcnt + 16'd1;
      INIT: begin
        state_n  = H_EN;
        nxt_rs   = 1'b0;
        nxt_byte = init_byte(init_idx);
      end
      IDLE: if (tick && pick0) begin
        gnt0     = 1'b1;
        state_n  = H_EN;
        nxt_rs   = rs0;
        nxt_byte = dat0;
      end else if (tick && pick1) begin
        gnt1     = 1'b1;
        state_n  = H_EN;
        nxt_rs   = rs1;
        nxt_byte = dat1;
      end
      H_EN: state_n = H_LO;
      H_LO: state_n = L_EN;
      L_EN: state_n = L_LO;
      L_LO: if (clr_cmd && CLR_TICKS > 0) state_n = GAP;
            else begin state_n = post; take_post = 1'b1; end
      GAP:  if (int'(wcnt) + 1 >= CLR_TICKS) begin state_n = post; take_post = 1'b1; end
            else wcnt_n = wcnt + 16'd1;
      default: state_n = PWR;
    endcase
    set_done = take_post && !init_done && (init_idx == 2'd3);
    idx_inc  = take_post && !init_done && (init_idx != 2'd3);
  end

  always_ff @(posedge clk or negedge sw_n) begin
    if (!sw_n) begin
      state     <= PWR;
      tick_cnt  <= '0;
      wcnt      <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      owner     <= 1'b1;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= '0;
      lcd_en    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        state <= state_n;
        wcnt  <= wcnt_n;
        if (set_done) init_done <= 1'b1;
        if (idx_inc) init_idx <= init_idx + 2'd1;
        if (gnt0 || gnt1) owner <= gnt1;
        // Bus pins change only on phase entry; rs/db hold through LO, GAP and IDLE.
        case (state_n)
          H_EN: begin
            byte_q <= nxt_byte;
            rs_q   <= nxt_rs;
            lcd_rs <= nxt_rs;
            lcd_db <= nxt_byte[7:4];
            lcd_en <= 1'b1;
          end
          L_EN: begin
            lcd_db <= byte_q[3:0];
            lcd_en <= 1'b1;
          end
          default: lcd_en <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench: per-tick expected bus trace built from byte-level rules, randomized traffic.
module tb_lcd_bus_arbiter;
  localparam int DIV = 4;
  localparam int CLR = 3;
  localparam int PWR = 2;
  localparam int NDIR = 15;
  localparam int NRND = 40;

  logic clk = 1'b0;
  logic sw_n, req0, rs0, req1, rs1;
  logic [7:0] dat0, dat1;
  logic ack0, ack1, lcd_rs, lcd_rw, lcd_en, busy, init_done, owner;
  logic [3:0] lcd_db;
`ifdef LCD_LOCK_EN
  logic lock0, lock1;
`endif

  always #5 clk = ~clk;

  lcd_bus_arbiter #(.DIV(DIV), .CLR_TICKS(CLR), .PWR_TICKS(PWR)) dut (
    .clk(clk), .sw_n(sw_n),
    .req0(req0), .rs0(rs0), .dat0(dat0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .dat1(dat1), .ack1(ack1),
`ifdef LCD_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_db(lcd_db),
    .busy(busy), .init_done(init_done), .owner(owner)
  );

  typedef struct packed {
    logic en; logic rs; logic [3:0] db; logic rw; logic busy;
    logic a0; logic a1; logic idn; logic own;
  } obs_t;

  typedef struct packed {
    logic w0; logic rs0; logic [7:0] d0;
    logic w1; logic rs1; logic [7:0] d1;
    logic lk0; logic lk1;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected outputs after each tick edge.
  obs_t q[$];
  logic m_owner, m_idone, m_rs;
  logic [3:0] m_db;
  logic pend0, pend1;

  row_t dir [NDIR] = '{
    '{1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b1, 1'b1, 8'h60, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0},
    '{1'b1, 1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{1'b1, 1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{1'b1, 1'b1, 8'h63, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
    '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1},
    '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}
  };

  function automatic obs_t ent(input logic en, input logic bsy, input logic a0, input logic a1);
    obs_t e;
    e = '{en:en, rs:m_rs, db:m_db, rw:1'b0, busy:bsy, a0:a0, a1:a1, idn:m_idone, own:m_owner};
    return e;
  endfunction

  // One byte on the bus: hi nibble strobe, lo nibble strobe, optional settle gap, then the next slot.
  task automatic m_byte(input int src, input logic rs, input logic [7:0] b, input bit is_init, input bit last);
    m_rs = rs;
    m_db = b[7:4];
    q.push_back(ent(1'b1, 1'b1, src == 0, src == 1));
    q.push_back(ent(1'b0, 1'b1, 1'b0, 1'b0));
    m_db = b[3:0];
    q.push_back(ent(1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(ent(1'b0, 1'b1, 1'b0, 1'b0));
    if (!rs && (b == 8'h01 || b == 8'h02))
      repeat (CLR) q.push_back(ent(1'b0, 1'b1, 1'b0, 1'b0));
    if (is_init && !last) q.push_back(ent(1'b0, 1'b1, 1'b0, 1'b0));
    else begin
      if (is_init) m_idone = 1'b1;
      q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic tick(output obs_t o);
    logic a0, a1;
    repeat (DIV - 1) @(posedge clk);
    @(negedge clk);
    a0 = ack0;
    a1 = ack1;
    @(posedge clk);
    #1;
    o = '{en:lcd_en, rs:lcd_rs, db:lcd_db, rw:lcd_rw, busy:busy, a0:a0, a1:a1, idn:init_done, own:owner};
  endtask

  function automatic logic [7:0] pick_dat();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'h01;
    if (s == 1) return 8'h02;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic test_reset();
    obs_t o, e;
    int step;
    sw_n = 1'b0;
    req0 = 1'b0; rs0 = 1'b0; dat0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; dat1 = 8'h00;
`ifdef LCD_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    m_owner = 1'b1; m_idone = 1'b0; m_rs = 1'b0; m_db = 4'h0;
    pend0 = 1'b0; pend1 = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    o = '{en:lcd_en, rs:lcd_rs, db:lcd_db, rw:lcd_rw, busy:busy, a0:ack0, a1:ack1, idn:init_done, own:owner};
    e = ent(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_state: got {en,rs,db,rw,busy,ack0,ack1,done,owner}=%b want %b", o, e);
    end
    @(negedge clk);
    sw_n = 1'b1;
    repeat (PWR) q.push_back(ent(1'b0, 1'b1, 1'b0, 1'b0));
    m_byte(-1, 1'b0, 8'h28, 1'b1, 1'b0);
    m_byte(-1, 1'b0, 8'h0C, 1'b1, 1'b0);
    m_byte(-1, 1'b0, 8'h06, 1'b1, 1'b0);
    m_byte(-1, 1'b0, 8'h01, 1'b1, 1'b1);
    step = 0;
    while (q.size() > 0) begin
      tick(o);
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL init_seq tick %0d: got {en,rs,db,rw,busy,ack0,ack1,done,owner}=%b want %b", step, o, e);
      end
      step++;
    end
  endtask

  task automatic test_traffic();
    row_t r;
    obs_t o, e;
    int g;
    bit first;
    logic lk0, lk1, locked;
    for (int n = 0; n < NDIR + NRND; n++) begin
      if (n < NDIR) r = dir[n];
      else begin
        r.w0 = ($urandom_range(0, 9) < 6); r.rs0 = 1'($urandom_range(0, 1)); r.d0 = pick_dat();
        r.w1 = ($urandom_range(0, 9) < 6); r.rs1 = 1'($urandom_range(0, 1)); r.d1 = pick_dat();
        r.lk0 = ($urandom_range(0, 3) == 0); r.lk1 = ($urandom_range(0, 3) == 0);
      end
      if (!pend0 && r.w0) begin pend0 = 1'b1; req0 = 1'b1; rs0 = r.rs0; dat0 = r.d0; end
      if (!pend1 && r.w1) begin pend1 = 1'b1; req1 = 1'b1; rs1 = r.rs1; dat1 = r.d1; end
      lk0 = r.lk0;
      lk1 = r.lk1;
      locked = 1'b0;
`ifdef LCD_LOCK_EN
      lock0 = lk0; lock1 = lk1;
      locked = m_owner ? lk1 : lk0;
`endif
      g = -1;
      if (locked) begin
        if (m_owner ? pend1 : pend0) g = m_owner ? 1 : 0;
      end else if (pend0 && pend1) g = m_owner ? 0 : 1;
      else if (pend0) g = 0;
      else if (pend1) g = 1;
      if (g < 0) q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b0));
      else begin
        m_owner = (g == 1);
        if (g == 0) m_byte(0, rs0, dat0, 1'b0, 1'b0);
        else m_byte(1, rs1, dat1, 1'b0, 1'b0);
      end
      first = 1'b1;
      while (q.size() > 0) begin
        tick(o);
        e = q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL traffic round %0d grant %0d: got {en,rs,db,rw,busy,ack0,ack1,done,owner}=%b want %b",
                   n, g, o, e);
        end
        // Scramble the served requester's inputs mid-flight; the latched byte must not change.
        if (first && g == 0) begin pend0 = 1'b0; req0 = 1'b0; rs0 = ~rs0; dat0 = 8'($urandom); end
        if (first && g == 1) begin pend1 = 1'b0; req1 = 1'b0; rs1 = ~rs1; dat1 = 8'($urandom); end
        first = 1'b0;
      end
      if (lk0 === 1'bx) $display("lock state unknown");
    end
`ifdef LCD_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    pend1 = 1'b0; req1 = 1'b0;
    pend0 = 1'b1; req0 = 1'b1; rs0 = 1'b1; dat0 = 8'hA5;
    m_owner = 1'b0;
    m_byte(0, 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(o);
      e = q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_reset lead-in tick %0d: got %b want %b", i, o, e);
      end
      if (i == 0) begin pend0 = 1'b0; req0 = 1'b0; end
    end
    q.delete();
    @(negedge clk);
    sw_n = 1'b0;
    #1;
    checks++;
    if ({lcd_en, lcd_rs, lcd_db, init_done, busy, owner} !== 9'b0_0_0000_0_1_1) begin
      errors++;
      $display("FAIL mid_reset_outputs: got {en,rs,db,done,busy,owner}=%b want 000000011",
               {lcd_en, lcd_rs, lcd_db, init_done, busy, owner});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_traffic();
    test_mid_reset();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
